// File: rtl/demux8_reg.sv
// demux8_reg: routes one WIDTH-bit input word into one of eight registered
// destinations and tracks a per-destination "unconsumed data" flag.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   rst      - synchronous active-high reset (wins over wr_en/rd_clr)
//   in       - source data
//   sel      - destination index, 0 -> out1 ... 7 -> out8
//   wr_en    - write strobe, captures in into destination sel
//   rd_clr   - per-destination consume strobe, bit i-1 clears valid of out{i}
//   out1..8  - registered destination values
//   valid    - per-destination unconsumed-data flags
//   ovf      - sticky per-destination overwrite flags
//   pending  - registered popcount of valid
module demux8_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       sel,
  input  logic             wr_en,
  input  logic [7:0]       rd_clr,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [7:0]       valid,
  output logic [7:0]       ovf,
  output logic [3:0]       pending
);

  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       valid_nxt;
  logic [7:0]       ovf_nxt;
  logic [3:0]       pending_nxt;

  // A write to the same index as a consume takes priority: valid stays set
  // and no overwrite is flagged, because the old data was consumed.
  always_comb begin
    valid_nxt   = valid & ~rd_clr;
    ovf_nxt     = ovf;
    pending_nxt = '0;
    if (wr_en) begin
      valid_nxt[sel] = 1'b1;
      if (valid[sel] && !rd_clr[sel]) begin
        ovf_nxt[sel] = 1'b1;
      end
    end
    // pending is counted from the next-state flags so it lands on the
    // same edge as valid.
    for (int unsigned i = 0; i < 8; i++) begin
      pending_nxt = pending_nxt + 4'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
      valid   <= '0;
      ovf     <= '0;
      pending <= '0;
    end else begin
      if (wr_en) begin
        data_q[sel] <= in;
      end
      valid   <= valid_nxt;
      ovf     <= ovf_nxt;
      pending <= pending_nxt;
    end
  end

  assign out1 = data_q[0];
  assign out2 = data_q[1];
  assign out3 = data_q[2];
  assign out4 = data_q[3];
  assign out5 = data_q[4];
  assign out6 = data_q[5];
  assign out7 = data_q[6];
  assign out8 = data_q[7];

endmodule

// File: tb/tb_demux8_reg.sv
// Self-checking bench for demux8_reg: directed scenarios followed by random
// traffic, every step compared against a behavioural model of the eight
// destinations.
module tb_demux8_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic [2:0]  sel;
  logic        wr_en;
  logic [7:0]  rd_clr;
  logic [31:0] out1, out2, out3, out4, out5, out6, out7, out8;
  logic [7:0]  valid;
  logic [7:0]  ovf;
  logic [3:0]  pending;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  logic [31:0] m_out [8];
  logic [7:0]  m_valid;
  logic [7:0]  m_ovf;

  always #5 clk = ~clk;

  demux8_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .wr_en(wr_en), .rd_clr(rd_clr),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out5(out5), .out6(out6), .out7(out7), .out8(out8),
    .valid(valid), .ovf(ovf), .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] dout [8];
    dout = '{out1, out2, out3, out4, out5, out6, out7, out8};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s.out%0d", tag, i + 1), dout[i], m_out[i]);
    end
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".pending"}, 32'(pending), 32'($countones(m_valid)));
  endtask

  // Drive one cycle, advance the model by the written rules, then compare.
  task automatic step(input logic r, input logic w, input logic [2:0] s,
                      input logic [31:0] d, input logic [7:0] c, input string tag);
    rst = r; wr_en = w; sel = s; in = d; rd_clr = c;
    if (r) begin
      for (int i = 0; i < 8; i++) m_out[i] = 32'h0;
      m_valid = 8'h00;
      m_ovf   = 8'h00;
    end else begin
      if (w) begin
        if (m_valid[s] == 1'b1 && c[s] == 1'b0) m_ovf[s] = 1'b1;
        m_out[s] = d;
      end
      for (int i = 0; i < 8; i++) if (c[i]) m_valid[i] = 1'b0;
      if (w) m_valid[s] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; sel = '0; in = '0; rd_clr = '0;
    for (int i = 0; i < 8; i++) m_out[i] = 32'hx;
    m_valid = 8'hxx;
    m_ovf   = 8'hxx;
    #1;

    // Reset, then single write to out3
    step(1, 0, 3'd0, 32'h0, 8'h00, "rst0");
    step(1, 0, 3'd0, 32'h0, 8'h00, "rst1");
    step(0, 1, 3'd2, 32'hDEADBEEF, 8'h00, "wr_out3");
    check("wr_out3.const_valid", 32'(valid), 32'h04);
    check("wr_out3.const_out3", out3, 32'hDEADBEEF);

    // Eight back-to-back writes
    step(1, 0, 3'd0, 32'h0, 8'h00, "rst_b2b");
    for (int s = 0; s < 8; s++) step(0, 1, 3'(s), 32'h11 * (s + 1), 8'h00, "b2b");
    check("b2b.const_valid", 32'(valid), 32'hFF);
    check("b2b.const_pending", 32'(pending), 32'd8);
    check("b2b.const_out8", out8, 32'h88);

    // All-valid consume with mask A5
    step(0, 0, 3'd0, 32'h0, 8'hA5, "clr_A5");
    check("clr_A5.const_valid", 32'(valid), 32'h5A);
    check("clr_A5.const_pending", 32'(pending), 32'd4);

    // Overwrite sets sticky ovf; consume keeps ovf and data
    step(1, 0, 3'd0, 32'h0, 8'h00, "rst_ovf");
    step(0, 1, 3'd1, 32'd5, 8'h00, "ovf_w1");
    step(0, 1, 3'd1, 32'd7, 8'h00, "ovf_w2");
    check("ovf_w2.const_ovf", 32'(ovf), 32'h02);
    step(0, 0, 3'd1, 32'd0, 8'h02, "ovf_clr");
    check("ovf_clr.const_ovf", 32'(ovf), 32'h02);
    check("ovf_clr.const_out2", out2, 32'd7);
    // Consume of an already-empty destination is ignored
    step(0, 0, 3'd0, 32'd0, 8'h02, "clr_empty");

    // Write and consume on the same index in one cycle
    step(0, 1, 3'd3, 32'd4, 8'h00, "same_w1");
    step(0, 1, 3'd3, 32'd9, 8'h08, "same_wc");
    check("same_wc.const_ovf3", 32'(ovf[3]), 32'd0);
    check("same_wc.const_valid3", 32'(valid[3]), 32'd1);

    // Reset with a coincident write
    step(0, 1, 3'd0, 32'd3, 8'h00, "pre_rst");
    step(1, 1, 3'd0, 32'd1, 8'h00, "rst_wr");
    check("rst_wr.const_valid", 32'(valid), 32'h00);
    // Immediate resume after reset
    step(0, 1, 3'd7, 32'hCAFE, 8'h00, "resume");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom),
           $urandom, 8'($urandom & $urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
